// File: rtl/wb_commit_stage.sv
// Write-back / commit stage: GPR write port, CP0 subset, precise exception,
// interrupt and eret commit. Define WB_TIMER_INT_EN to enable the Count/Compare timer interrupt.
module wb_commit_stage #(
  parameter int          NUM_HW_INT = 6,
  parameter logic [31:0] EXC_VEC    = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ms_to_ws_valid,
  output logic                  ws_allowin,
  input  logic [31:0]           ms_pc,
  input  logic [3:0]            ms_gr_we,
  input  logic [4:0]            ms_dest,
  input  logic [31:0]           ms_result,
  input  logic                  ms_exc_valid,
  input  logic [4:0]            ms_exc_code,
  input  logic                  ms_is_slot,
  input  logic [31:0]           ms_bad_vaddr,
  input  logic                  ms_eret,
  input  logic                  ms_cp0_wen,
  input  logic                  ms_cp0_ren,
  input  logic [7:0]            ms_cp0_addr,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [3:0]            rf_we,
  output logic [4:0]            rf_waddr,
  output logic [31:0]           rf_wdata,
  output logic                  send_flush,
  output logic [31:0]           flush_pc,
  output logic [31:0]           debug_wb_pc,
  output logic [3:0]            debug_wb_rf_wen,
  output logic [4:0]            debug_wb_rf_wnum,
  output logic [31:0]           debug_wb_rf_wdata
);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic        is_slot;
    logic [31:0] bad_vaddr;
    logic        eret;
    logic        cp0_wen;
    logic        cp0_ren;
    logic [7:0]  cp0_addr;
  } ws_req_t;

  localparam logic [7:0] A_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] A_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
  localparam logic [3:0] DIV_MAX    = 4'(COUNT_DIV - 1);

  logic        ws_valid_q;
  ws_req_t     ws_q, ms_req;
  logic [31:0] badvaddr_q, count_q, compare_q, epc_q;
  logic [7:0]  im_q;
  logic        exl_q, ie_q, bd_q, ti;
  logic [4:0]  exccode_q;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q;
  logic [3:0]  div_q;
  logic [7:0]  cause_ip;
  logic [31:0] status_rd, cause_rd, cp0_rdata;
  logic        int_pending, take_exc, do_eret, commit, cp0_we;
  logic [4:0]  exc_code_eff;

  assign ms_req = '{pc: ms_pc, gr_we: ms_gr_we, dest: ms_dest, result: ms_result,
                    exc_valid: ms_exc_valid, exc_code: ms_exc_code, is_slot: ms_is_slot,
                    bad_vaddr: ms_bad_vaddr, eret: ms_eret, cp0_wen: ms_cp0_wen,
                    cp0_ren: ms_cp0_ren, cp0_addr: ms_cp0_addr};

  always_comb begin
    ip_hw_d = '0;
    for (int i = 0; i < NUM_HW_INT; i++) ip_hw_d[i] = hw_int[i];
  end

`ifdef WB_TIMER_INT_EN
  logic ti_q;
  // A Compare write beats a same-cycle match so software can always ack the timer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                              ti_q <= 1'b0;
    else if (cp0_we && ws_q.cp0_addr == A_COMPARE) ti_q <= 1'b0;
    else if (count_q == compare_q)            ti_q <= 1'b1;
  end
  assign ti       = ti_q;
  assign cause_ip = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
`else
  assign ti       = 1'b0;
  assign cause_ip = {ip_hw_q, ip_sw_q};
`endif

  assign status_rd = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
  assign cause_rd  = {bd_q, ti, 14'd0, cause_ip, 1'b0, exccode_q, 2'b00};

  always_comb begin
    cp0_rdata = 32'd0;
    case (ws_q.cp0_addr)
      A_BADVADDR: cp0_rdata = badvaddr_q;
      A_COUNT:    cp0_rdata = count_q;
      A_COMPARE:  cp0_rdata = compare_q;
      A_STATUS:   cp0_rdata = status_rd;
      A_CAUSE:    cp0_rdata = cause_rd;
      A_EPC:      cp0_rdata = epc_q;
      default:    cp0_rdata = 32'd0;
    endcase
  end

  // A synchronous exception keeps its own code even when an interrupt is also pending.
  assign int_pending  = ie_q && !exl_q && |(cause_ip & im_q);
  assign take_exc     = ws_valid_q && (ws_q.exc_valid || int_pending);
  assign exc_code_eff = ws_q.exc_valid ? ws_q.exc_code : 5'd0;
  assign do_eret      = ws_valid_q && !take_exc && ws_q.eret;
  assign commit       = ws_valid_q && !take_exc && !ws_q.eret;
  assign cp0_we       = commit && ws_q.cp0_wen;

  assign ws_allowin = 1'b1;
  assign send_flush = take_exc || do_eret;
  assign flush_pc   = take_exc ? EXC_VEC : epc_q;
  assign rf_we      = commit ? ws_q.gr_we : 4'd0;
  assign rf_waddr   = ws_q.dest;
  assign rf_wdata   = ws_q.cp0_ren ? cp0_rdata : ws_q.result;

  assign debug_wb_pc       = ws_q.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_valid_q <= 1'b0;
      ws_q       <= '0;
    end else begin
      if (send_flush)      ws_valid_q <= 1'b0;
      else if (ws_allowin) ws_valid_q <= ms_to_ws_valid;
      if (ms_to_ws_valid && ws_allowin) ws_q <= ms_req;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      epc_q      <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exccode_q  <= 5'd0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      div_q      <= 4'd0;
    end else begin
      ip_hw_q <= ip_hw_d;
      if (take_exc) begin
        // Nested exception under EXL keeps the original EPC/BD.
        if (!exl_q) begin
          epc_q <= ws_q.is_slot ? ws_q.pc - 32'd4 : ws_q.pc;
          bd_q  <= ws_q.is_slot;
        end
        exl_q     <= 1'b1;
        exccode_q <= exc_code_eff;
        if (exc_code_eff == 5'd4 || exc_code_eff == 5'd5) badvaddr_q <= ws_q.bad_vaddr;
      end else if (do_eret) begin
        exl_q <= 1'b0;
      end else if (cp0_we) begin
        case (ws_q.cp0_addr)
          A_COMPARE: compare_q <= ws_q.result;
          A_STATUS: begin
            im_q  <= ws_q.result[15:8];
            exl_q <= ws_q.result[1];
            ie_q  <= ws_q.result[0];
          end
          A_CAUSE:   ip_sw_q <= ws_q.result[9:8];
          A_EPC:     epc_q   <= ws_q.result;
          default: ;
        endcase
      end
      if (cp0_we && ws_q.cp0_addr == A_COUNT) begin
        count_q <= ws_q.result;
        div_q   <= 4'd0;
      end else if (div_q == DIV_MAX) begin
        div_q   <= 4'd0;
        count_q <= count_q + 32'd1;
      end else begin
        div_q <= div_q + 4'd1;
      end
    end
  end

endmodule
